// File: rtl/rename_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rename_stage_pkg
// Description : Shared types for the rename stage: group width, source count,
//               logical/physical register index types and the per-slot
//               renamed-instruction record handed to dispatch.
// Revision    : 1.0  initial release
// ============================================================================
package rename_stage_pkg;

    localparam int RENAME_WIDTH = 4;
    localparam int NUMSRCS_INT  = 2;
    localparam int ILR_W        = 5;
    localparam int IPR_W        = 7;

    typedef logic [ILR_W-1:0] ilrIdx_t;
    typedef logic [IPR_W-1:0] iprIdx_t;

    // prs[j] holds the physical mapping of logical source j.
    typedef struct packed {
        logic                         ismv;
        logic                         has_rd;
        ilrIdx_t                      lrd;
        iprIdx_t                      prd;
        iprIdx_t                      prev_prd;
        iprIdx_t [NUMSRCS_INT-1:0]    prs;
    } renamedInst_t;

endpackage
`default_nettype wire

// File: rtl/rename_intragroup_bypass.sv
`default_nettype none
// ============================================================================
// Module      : rename_intragroup_bypass
// Description : Purely combinational intra-group RAW/WAW fix-up. For every
//               slot the rename table only returns the pre-group mapping, so
//               a source (or the previous mapping of a destination) that is
//               written by an older slot of the same group must instead take
//               that older slot's new prd. The youngest older writer wins.
//               Logical r0 never bypasses a source.
// Ports       : i_vld/i_has_rd     per-slot valid and writes-register flags
//               i_lrd/i_lrs        logical destination / sources
//               i_rt_prd           new physical destinations from the table
//               i_rt_prev_prd      table previous mapping of each destination
//               i_rt_prs           table source mappings (pre-group)
//               o_prs/o_prev_prd   corrected source / previous mappings
// Revision    : 1.0  initial release
// ============================================================================
module rename_intragroup_bypass
    import rename_stage_pkg::*;
#(
    parameter int WIDTH   = RENAME_WIDTH,
    parameter int NUMSRCS = NUMSRCS_INT
) (
    input  logic    [WIDTH-1:0]               i_vld,
    input  logic    [WIDTH-1:0]               i_has_rd,
    input  ilrIdx_t [WIDTH-1:0]               i_lrd,
    input  ilrIdx_t [WIDTH-1:0][NUMSRCS-1:0]  i_lrs,
    input  iprIdx_t [WIDTH-1:0]               i_rt_prd,
    input  iprIdx_t [WIDTH-1:0]               i_rt_prev_prd,
    input  iprIdx_t [WIDTH-1:0][NUMSRCS-1:0]  i_rt_prs,
    output iprIdx_t [WIDTH-1:0][NUMSRCS-1:0]  o_prs,
    output iprIdx_t [WIDTH-1:0]               o_prev_prd
);

    logic [WIDTH-1:0] w_writer;

    assign w_writer = i_vld & i_has_rd;

    // Older slots are scanned in ascending order, so a later (younger) match
    // overwrites an earlier one and the youngest older writer is selected.
    always_comb begin
        o_prs      = i_rt_prs;
        o_prev_prd = i_rt_prev_prd;
        for (int i = 1; i < WIDTH; i++) begin
            for (int k = 0; k < i; k++) begin
                if (w_writer[k] && (i_lrd[k] == i_lrd[i])) begin
                    o_prev_prd[i] = i_rt_prd[k];
                end
                for (int j = 0; j < NUMSRCS; j++) begin
                    if (w_writer[k] && (i_lrd[k] == i_lrs[i][j]) &&
                        (i_lrd[k] != '0)) begin
                        o_prs[i][j] = i_rt_prd[k];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rename_stage.sv
`default_nettype none
// ============================================================================
// Module      : rename_stage
// Description : Rename pipeline stage between the decode queue and dispatch.
//               Drives rename-table lookups, applies the intra-group bypass
//               and registers the renamed group into an output latch drained
//               by dispatch with a whole-group valid/ready handshake. All
//               stall and squash gating lives here so that the rename table
//               and freelist only change on cycles where the group advances.
// Ports       : clk, rst            clock, synchronous active-high reset
//               i_squash_vld        pipeline squash
//               i_dec_*/o_dec_rdy   decode group in / accepted this cycle
//               o_rt_*/i_rt_*       rename table lookup and results
//               o_disp_*/i_disp_rdy renamed group out to dispatch
//               o_perf_*            stall counters (only with the macro)
// Options     : RENAME_STAGE_PERF_EN adds two saturating CNT_W stall counters
//               (o_perf_fl_stall, o_perf_disp_stall).
// Revision    : 1.0  initial release
// ============================================================================
module rename_stage
    import rename_stage_pkg::*;
#(
    parameter int WIDTH   = RENAME_WIDTH,
    parameter int NUMSRCS = NUMSRCS_INT,
    parameter int CNT_W   = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_squash_vld,
    input  logic    [WIDTH-1:0]               i_dec_vld,
    input  logic    [WIDTH-1:0]               i_dec_ismv,
    input  logic    [WIDTH-1:0]               i_dec_has_rd,
    input  ilrIdx_t [WIDTH-1:0]               i_dec_lrd,
    input  ilrIdx_t [WIDTH-1:0][NUMSRCS-1:0]  i_dec_lrs,
    output logic                              o_dec_rdy,
    output logic    [WIDTH-1:0]               o_rt_ismv,
    output logic    [WIDTH-1:0]               o_rt_has_rd,
    output ilrIdx_t [WIDTH-1:0]               o_rt_lrd,
    output ilrIdx_t [WIDTH-1:0][NUMSRCS-1:0]  o_rt_lrs,
    input  logic                              i_rt_can_rename,
    input  iprIdx_t [WIDTH-1:0]               i_rt_prd,
    input  iprIdx_t [WIDTH-1:0]               i_rt_prev_prd,
    input  iprIdx_t [WIDTH-1:0][NUMSRCS-1:0]  i_rt_prs,
    output logic    [WIDTH-1:0]               o_disp_vld,
    output renamedInst_t [WIDTH-1:0]          o_disp_grp,
    input  logic                              i_disp_rdy
`ifdef RENAME_STAGE_PERF_EN
    ,
    output logic    [CNT_W-1:0]               o_perf_fl_stall,
    output logic    [CNT_W-1:0]               o_perf_disp_stall
`endif
);

    logic                             w_in_any;
    logic                             w_out_free;
    logic                             w_fire;
    logic                             w_rt_gate;
    iprIdx_t [WIDTH-1:0][NUMSRCS-1:0] w_byp_prs;
    iprIdx_t [WIDTH-1:0]              w_byp_prev_prd;
    renamedInst_t [WIDTH-1:0]         w_grp;

    logic [WIDTH-1:0]                 r_disp_vld_q;
    logic [WIDTH-1:0]                 w_disp_vld_d;
    renamedInst_t [WIDTH-1:0]         r_disp_grp_q;
    renamedInst_t [WIDTH-1:0]         w_disp_grp_d;

    assign w_in_any   = |i_dec_vld;
    assign w_out_free = ~(|r_disp_vld_q) | i_disp_rdy;
    assign w_fire     = w_in_any & i_rt_can_rename & w_out_free & ~i_squash_vld;

    // can_rename is deliberately left out of the table write-enable gating:
    // the table qualifies with it internally, and including it here would
    // close a combinational loop through the freelist.
    assign w_rt_gate  = w_in_any & w_out_free & ~i_squash_vld;

    assign o_dec_rdy   = w_fire;
    assign o_rt_has_rd = i_dec_has_rd & i_dec_vld & {WIDTH{w_rt_gate}};
    assign o_rt_ismv   = i_dec_ismv   & i_dec_vld & {WIDTH{w_rt_gate}};
    assign o_rt_lrd    = i_dec_lrd;
    assign o_rt_lrs    = i_dec_lrs;

    rename_intragroup_bypass #(
        .WIDTH   (WIDTH),
        .NUMSRCS (NUMSRCS)
    ) u_bypass (
        .i_vld         (i_dec_vld),
        .i_has_rd      (i_dec_has_rd),
        .i_lrd         (i_dec_lrd),
        .i_lrs         (i_dec_lrs),
        .i_rt_prd      (i_rt_prd),
        .i_rt_prev_prd (i_rt_prev_prd),
        .i_rt_prs      (i_rt_prs),
        .o_prs         (w_byp_prs),
        .o_prev_prd    (w_byp_prev_prd)
    );

    // Invalid slots are emitted as all-zero records.
    always_comb begin
        w_grp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_dec_vld[i]) begin
                w_grp[i].ismv     = i_dec_ismv[i];
                w_grp[i].has_rd   = i_dec_has_rd[i];
                w_grp[i].lrd      = i_dec_lrd[i];
                w_grp[i].prd      = i_rt_prd[i];
                w_grp[i].prev_prd = w_byp_prev_prd[i];
                for (int j = 0; j < NUMSRCS; j++) begin
                    w_grp[i].prs[j] = w_byp_prs[i][j];
                end
            end
        end
    end

    // Output latch: squash beats fire beats drain; otherwise hold. The
    // payload only loads on fire so it stays stable while dispatch stalls.
    always_comb begin
        w_disp_vld_d = r_disp_vld_q;
        w_disp_grp_d = r_disp_grp_q;
        if (i_squash_vld) begin
            w_disp_vld_d = '0;
        end else if (w_fire) begin
            w_disp_vld_d = i_dec_vld;
            w_disp_grp_d = w_grp;
        end else if (i_disp_rdy) begin
            w_disp_vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_vld_q <= '0;
            r_disp_grp_q <= '0;
        end else begin
            r_disp_vld_q <= w_disp_vld_d;
            r_disp_grp_q <= w_disp_grp_d;
        end
    end

    assign o_disp_vld = r_disp_vld_q;
    assign o_disp_grp = r_disp_grp_q;

`ifdef RENAME_STAGE_PERF_EN
    logic [CNT_W-1:0] r_perf_fl_stall_q;
    logic [CNT_W-1:0] w_perf_fl_stall_d;
    logic [CNT_W-1:0] r_perf_disp_stall_q;
    logic [CNT_W-1:0] w_perf_disp_stall_d;

    // Saturating: stop at all-ones rather than wrapping to zero.
    always_comb begin
        w_perf_fl_stall_d   = r_perf_fl_stall_q;
        w_perf_disp_stall_d = r_perf_disp_stall_q;
        if (w_in_any && !i_rt_can_rename && w_out_free && !(&r_perf_fl_stall_q)) begin
            w_perf_fl_stall_d = r_perf_fl_stall_q + 1'b1;
        end
        if (w_in_any && !w_out_free && !(&r_perf_disp_stall_q)) begin
            w_perf_disp_stall_d = r_perf_disp_stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fl_stall_q   <= '0;
            r_perf_disp_stall_q <= '0;
        end else begin
            r_perf_fl_stall_q   <= w_perf_fl_stall_d;
            r_perf_disp_stall_q <= w_perf_disp_stall_d;
        end
    end

    assign o_perf_fl_stall   = r_perf_fl_stall_q;
    assign o_perf_disp_stall = r_perf_disp_stall_q;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W == 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_stage
// Description : Self-checking bench for rename_stage: a table of single-cycle
//               group vectors followed by multi-cycle sequences for freelist
//               stall, dispatch backpressure, squash and mid-stream reset.
//               Table-side values are fixed: prd[i]=40+i, prev_prd[i]=20+i,
//               prs[i][j]=8+2i+j.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rename_stage;
    import rename_stage_pkg::*;

    localparam int W = RENAME_WIDTH;
    localparam int S = NUMSRCS_INT;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      squash;
    logic    [W-1:0]           dec_vld, dec_ismv, dec_has_rd;
    ilrIdx_t [W-1:0]           dec_lrd;
    ilrIdx_t [W-1:0][S-1:0]    dec_lrs;
    logic                      dec_rdy;
    logic    [W-1:0]           rt_ismv, rt_has_rd;
    ilrIdx_t [W-1:0]           rt_lrd;
    ilrIdx_t [W-1:0][S-1:0]    rt_lrs;
    logic                      can_rename;
    iprIdx_t [W-1:0]           rt_prd, rt_prev_prd;
    iprIdx_t [W-1:0][S-1:0]    rt_prs;
    logic    [W-1:0]           disp_vld;
    renamedInst_t [W-1:0]      disp_grp;
    logic                      disp_rdy;

    rename_stage dut (
        .clk             (clk),
        .rst             (rst),
        .i_squash_vld    (squash),
        .i_dec_vld       (dec_vld),
        .i_dec_ismv      (dec_ismv),
        .i_dec_has_rd    (dec_has_rd),
        .i_dec_lrd       (dec_lrd),
        .i_dec_lrs       (dec_lrs),
        .o_dec_rdy       (dec_rdy),
        .o_rt_ismv       (rt_ismv),
        .o_rt_has_rd     (rt_has_rd),
        .o_rt_lrd        (rt_lrd),
        .o_rt_lrs        (rt_lrs),
        .i_rt_can_rename (can_rename),
        .i_rt_prd        (rt_prd),
        .i_rt_prev_prd   (rt_prev_prd),
        .i_rt_prs        (rt_prs),
        .o_disp_vld      (disp_vld),
        .o_disp_grp      (disp_grp),
        .i_disp_rdy      (disp_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]           vld, ismv, has;
        ilrIdx_t [W-1:0]        lrd;
        ilrIdx_t [W-1:0][S-1:0] lrs;
        logic                   sq;
        logic                   e_rdy;
        logic [W-1:0]           e_has, e_ismv, e_vld;
        logic                   chk_grp;
        renamedInst_t [W-1:0]   e_grp;
    } vec_t;

    vec_t vecs [8];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic renamedInst_t rec(input logic m, input logic h, input int lrd,
                                         input int prd, input int prev, input int p0, input int p1);
        renamedInst_t r;
        r.ismv     = m;
        r.has_rd   = h;
        r.lrd      = ilrIdx_t'(lrd);
        r.prd      = iprIdx_t'(prd);
        r.prev_prd = iprIdx_t'(prev);
        r.prs[0]   = iprIdx_t'(p0);
        r.prs[1]   = iprIdx_t'(p1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic [W-1:0] v, input logic [W-1:0] m, input logic [W-1:0] h,
                         input ilrIdx_t [W-1:0] lrd, input ilrIdx_t [W-1:0][S-1:0] lrs);
        dec_vld = v; dec_ismv = m; dec_has_rd = h; dec_lrd = lrd; dec_lrs = lrs;
    endtask

    task automatic idle_in();
        drive('0, '0, '0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.vld = '0; v.ismv = '0; v.has = '0; v.lrd = '0; v.lrs = '0; v.sq = 1'b0;
        v.e_rdy = 1'b0; v.e_has = '0; v.e_ismv = '0; v.e_vld = '0;
        v.chk_grp = 1'b0; v.e_grp = '0;
        return v;
    endfunction

    renamedInst_t [W-1:0] g_exp, h_exp;
    ilrIdx_t [W-1:0]        g_lrd, h_lrd;
    ilrIdx_t [W-1:0][S-1:0] g_lrs, h_lrs;
    int                     qual;

    initial begin
        // ---------------- table setup ----------------
        for (int i = 0; i < 8; i++) vecs[i] = blank();
        // basic rename
        vecs[0].vld = 4'b0011; vecs[0].has = 4'b0011;
        vecs[0].lrd[0] = 5; vecs[0].lrd[1] = 6;
        vecs[0].lrs[0][0] = 1; vecs[0].lrs[0][1] = 2; vecs[0].lrs[1][0] = 3; vecs[0].lrs[1][1] = 4;
        vecs[0].e_rdy = 1; vecs[0].e_has = 4'b0011; vecs[0].e_vld = 4'b0011; vecs[0].chk_grp = 1;
        vecs[0].e_grp[0] = rec(0, 1, 5, 40, 20, 8, 9);
        vecs[0].e_grp[1] = rec(0, 1, 6, 41, 21, 10, 11);
        // slot1 reads r5 written by slot0
        vecs[1] = vecs[0];
        vecs[1].lrs[1][0] = 5; vecs[1].lrs[1][1] = 3;
        vecs[1].e_grp[1] = rec(0, 1, 6, 41, 21, 40, 11);
        // two writers of r7, slot2 reads r7
        vecs[2].vld = 4'b0111; vecs[2].has = 4'b0011;
        vecs[2].lrd[0] = 7; vecs[2].lrd[1] = 7; vecs[2].lrd[2] = 0;
        vecs[2].lrs[0][0] = 1; vecs[2].lrs[0][1] = 2; vecs[2].lrs[1][0] = 3; vecs[2].lrs[1][1] = 4;
        vecs[2].lrs[2][0] = 7; vecs[2].lrs[2][1] = 1;
        vecs[2].e_rdy = 1; vecs[2].e_has = 4'b0011; vecs[2].e_vld = 4'b0111; vecs[2].chk_grp = 1;
        vecs[2].e_grp[0] = rec(0, 1, 7, 40, 20, 8, 9);
        vecs[2].e_grp[1] = rec(0, 1, 7, 41, 40, 10, 11);
        vecs[2].e_grp[2] = rec(0, 0, 0, 42, 22, 41, 13);
        // r0 written by slot0 is not bypassed; slot1 is a move
        vecs[3].vld = 4'b0011; vecs[3].has = 4'b0011; vecs[3].ismv = 4'b0010;
        vecs[3].lrd[0] = 0; vecs[3].lrd[1] = 3;
        vecs[3].lrs[0][0] = 1; vecs[3].lrs[0][1] = 2;
        vecs[3].e_rdy = 1; vecs[3].e_has = 4'b0011; vecs[3].e_ismv = 4'b0010;
        vecs[3].e_vld = 4'b0011; vecs[3].chk_grp = 1;
        vecs[3].e_grp[0] = rec(0, 1, 0, 40, 20, 8, 9);
        vecs[3].e_grp[1] = rec(1, 1, 3, 41, 21, 10, 11);
        // full group with chained dependencies
        vecs[4].vld = 4'b1111; vecs[4].has = 4'b1111;
        vecs[4].lrd[0] = 1; vecs[4].lrd[1] = 2; vecs[4].lrd[2] = 1; vecs[4].lrd[3] = 3;
        vecs[4].lrs[0][0] = 1; vecs[4].lrs[0][1] = 2; vecs[4].lrs[1][0] = 1; vecs[4].lrs[1][1] = 5;
        vecs[4].lrs[2][0] = 2; vecs[4].lrs[2][1] = 1; vecs[4].lrs[3][0] = 1; vecs[4].lrs[3][1] = 2;
        vecs[4].e_rdy = 1; vecs[4].e_has = 4'b1111; vecs[4].e_vld = 4'b1111; vecs[4].chk_grp = 1;
        vecs[4].e_grp[0] = rec(0, 1, 1, 40, 20, 8, 9);
        vecs[4].e_grp[1] = rec(0, 1, 2, 41, 21, 40, 11);
        vecs[4].e_grp[2] = rec(0, 1, 1, 42, 40, 41, 40);
        vecs[4].e_grp[3] = rec(0, 1, 3, 43, 23, 42, 41);
        // flags on an invalid slot are dropped
        vecs[5].vld = 4'b0001; vecs[5].has = 4'b0011; vecs[5].ismv = 4'b0010;
        vecs[5].lrd[0] = 4; vecs[5].lrd[1] = 4;
        vecs[5].lrs[0][0] = 4; vecs[5].lrs[0][1] = 4; vecs[5].lrs[1][0] = 4; vecs[5].lrs[1][1] = 4;
        vecs[5].e_rdy = 1; vecs[5].e_has = 4'b0001; vecs[5].e_vld = 4'b0001; vecs[5].chk_grp = 1;
        vecs[5].e_grp[0] = rec(0, 1, 4, 40, 20, 8, 9);
        // idle cycle drains the latch
        vecs[6].e_vld = '0;
        // single-cycle squash with a fireable group
        vecs[7] = vecs[0];
        vecs[7].sq = 1; vecs[7].e_rdy = 0; vecs[7].e_has = '0; vecs[7].e_vld = '0; vecs[7].chk_grp = 0;

        for (int i = 0; i < W; i++) begin
            rt_prd[i]      = iprIdx_t'(40 + i);
            rt_prev_prd[i] = iprIdx_t'(20 + i);
            for (int j = 0; j < S; j++) rt_prs[i][j] = iprIdx_t'(8 + 2 * i + j);
        end

        // ---------------- reset ----------------
        rst = 1; squash = 0; can_rename = 1; disp_rdy = 1;
        idle_in();
        tick(); tick();
        rst = 0;
        #3;
        chk("reset_disp_vld", 256'(disp_vld), 256'(0));
        chk("reset_disp_grp", 256'(disp_grp), 256'(0));
        chk("reset_dec_rdy",  256'(dec_rdy), 256'(0));
        chk("reset_rt_has_rd", 256'(rt_has_rd), 256'(0));
        chk("reset_rt_ismv",  256'(rt_ismv), 256'(0));
        tick();

        // ---------------- table ----------------
        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].vld, vecs[v].ismv, vecs[v].has, vecs[v].lrd, vecs[v].lrs);
            squash = vecs[v].sq;
            #3;
            chk($sformatf("v%0d_dec_rdy", v), 256'(dec_rdy), 256'(vecs[v].e_rdy));
            chk($sformatf("v%0d_rt_has_rd", v), 256'(rt_has_rd), 256'(vecs[v].e_has));
            chk($sformatf("v%0d_rt_ismv", v), 256'(rt_ismv), 256'(vecs[v].e_ismv));
            if (v == 0) chk("v0_rt_lrd", 256'(rt_lrd), 256'(vecs[0].lrd));
            tick();
            chk($sformatf("v%0d_disp_vld", v), 256'(disp_vld), 256'(vecs[v].e_vld));
            if (vecs[v].chk_grp) chk($sformatf("v%0d_disp_grp", v), 256'(disp_grp), 256'(vecs[v].e_grp));
        end
        squash = 0;
        idle_in();
        tick();

        // ---------------- freelist stall ----------------
        g_lrd = '0; g_lrs = '0;
        g_lrd[0] = 5; g_lrd[1] = 6;
        g_lrs[0][0] = 1; g_lrs[0][1] = 2; g_lrs[1][0] = 3; g_lrs[1][1] = 4;
        g_exp = '0;
        g_exp[0] = rec(0, 1, 5, 40, 20, 8, 9);
        g_exp[1] = rec(0, 1, 6, 41, 21, 10, 11);
        qual = 0;
        drive(4'b0011, '0, 4'b0011, g_lrd, g_lrs);
        can_rename = 0;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("fl_stall%0d_dec_rdy", c), 256'(dec_rdy), 256'(0));
            if (rt_has_rd != 0 && can_rename) qual++;
            tick();
            chk($sformatf("fl_stall%0d_disp_vld", c), 256'(disp_vld), 256'(0));
        end
        can_rename = 1;
        #3;
        chk("fl_fire_dec_rdy", 256'(dec_rdy), 256'(1));
        if (rt_has_rd != 0 && can_rename) qual++;
        tick();
        chk("fl_fire_disp_vld", 256'(disp_vld), 256'(4'b0011));
        chk("fl_fire_disp_grp", 256'(disp_grp), 256'(g_exp));
        chk("fl_qualified_cycles", 256'(qual), 256'(1));

        // ---------------- dispatch backpressure ----------------
        h_lrd = '0; h_lrs = '0;
        h_lrd[0] = 9; h_lrs[0][0] = 7; h_lrs[0][1] = 8;
        h_exp = '0;
        h_exp[0] = rec(0, 1, 9, 40, 20, 8, 9);
        drive(4'b0001, '0, 4'b0001, h_lrd, h_lrs);
        disp_rdy = 0;
        for (int c = 0; c < 2; c++) begin
            #3;
            chk($sformatf("bp%0d_dec_rdy", c), 256'(dec_rdy), 256'(0));
            chk($sformatf("bp%0d_rt_has_rd", c), 256'(rt_has_rd), 256'(0));
            tick();
            chk($sformatf("bp%0d_disp_vld", c), 256'(disp_vld), 256'(4'b0011));
            chk($sformatf("bp%0d_disp_grp", c), 256'(disp_grp), 256'(g_exp));
        end
        disp_rdy = 1;
        #3;
        chk("bp_release_dec_rdy", 256'(dec_rdy), 256'(1));
        tick();
        chk("bp_release_disp_vld", 256'(disp_vld), 256'(4'b0001));
        chk("bp_release_disp_grp", 256'(disp_grp), 256'(h_exp));

        // ---------------- squash while holding and firing ----------------
        drive(4'b0011, '0, 4'b0011, g_lrd, g_lrs);
        squash = 1;
        #3;
        chk("sq_dec_rdy", 256'(dec_rdy), 256'(0));
        chk("sq_rt_has_rd", 256'(rt_has_rd), 256'(0));
        tick();
        chk("sq_disp_vld", 256'(disp_vld), 256'(0));
        squash = 0;
        // refill, then squash a held group under backpressure
        tick();
        chk("sq_refill_disp_vld", 256'(disp_vld), 256'(4'b0011));
        disp_rdy = 0;
        squash = 1;
        #3;
        chk("sq_held_dec_rdy", 256'(dec_rdy), 256'(0));
        tick();
        chk("sq_held_disp_vld", 256'(disp_vld), 256'(0));
        squash = 0;
        disp_rdy = 1;

        // ---------------- reset mid-stream ----------------
        tick();
        chk("rst_pre_disp_vld", 256'(disp_vld), 256'(4'b0011));
        rst = 1;
        tick();
        rst = 0;
        idle_in();
        #3;
        chk("rst_mid_disp_vld", 256'(disp_vld), 256'(0));
        chk("rst_mid_disp_grp", 256'(disp_grp), 256'(0));
        chk("rst_mid_dec_rdy", 256'(dec_rdy), 256'(0));
        chk("rst_mid_rt_has_rd", 256'(rt_has_rd), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
